// File: rtl/spi_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : spi_arb_pkg
//  Purpose  : Shared encodings for the SPI master arbiter: the arbiter's own
//             state encoding and the IO engine's idle state code.
//  Revision : 1.0  initial release
// ============================================================================
package spi_arb_pkg;

  typedef enum logic [1:0] {
    SPI_ARB_IDLE  = 2'd0,
    SPI_ARB_SEND  = 2'd1,
    SPI_ARB_WAIT  = 2'd2,
    SPI_ARB_DRAIN = 2'd3
  } spi_arb_state_e;

  // State code reported by the SPI master IO engine when it is idle
  localparam logic [2:0] SPI_IO_IDLE = 3'b000;

endpackage : spi_arb_pkg
`default_nettype wire

// File: rtl/spi_arb_rr.sv
`default_nettype none
// ============================================================================
//  Module   : spi_arb_rr
//  Purpose  : Combinational round-robin priority picker. Searches req from
//             last_owner+1 upward, wrapping modulo N, and reports the first
//             set bit.
//  Ports    : req        [N]     request vector
//             last_owner [IDXW]  index of the previous owner
//             sel        [N]     one-hot selection
//             idx        [IDXW]  encoded selection
//             any        1       at least one request present
//  Revision : 1.0  initial release
// ============================================================================
module spi_arb_rr
  import spi_arb_pkg::*;
#(
  parameter int N    = 4,
  parameter int IDXW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req,
  input  logic [IDXW-1:0] last_owner,
  output logic [N-1:0]    sel,
  output logic [IDXW-1:0] idx,
  output logic            any
);

  always_comb begin
    logic [IDXW:0]   sum;
    logic [IDXW-1:0] cand;
    sel  = '0;
    idx  = '0;
    any  = 1'b0;
    sum  = '0;
    cand = '0;
    // Candidate k steps after last_owner; k = N revisits last_owner itself last.
    for (int k = 1; k <= N; k++) begin
      sum = {1'b0, last_owner} + (IDXW+1)'(k);
      if (sum >= (IDXW+1)'(N)) begin
        sum = sum - (IDXW+1)'(N);
      end
      cand = sum[IDXW-1:0];
      if (!any && req[cand]) begin
        any       = 1'b1;
        sel[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule : spi_arb_rr
`default_nettype wire

// File: rtl/spi_master_arb.sv
`default_nettype none
// ============================================================================
//  Module   : spi_master_arb
//  Purpose  : Shares one SPI master IO engine between N requesters. Latches a
//             1..8 byte transaction from the round-robin winner, feeds it to
//             the engine's FIFO-style byte port, waits for the end-of-transfer
//             pulse and returns the 64-bit receive word to the owner.
//  Ports    : clk, nreset              clock, async active-low reset
//             req/req_len/req_data     per-requester transaction inputs
//             gnt/done                 one-hot accept / completion pulses
//             rsp_data                 receive word, held until next done
//             busy                     not idle
//             io_dout/io_empty/io_read engine byte (FIFO) interface
//             io_spi_state             engine state, 3'b000 = idle
//             io_rx_access/io_rx_data  engine end-of-transfer and rx word
//  Revision : 1.0  initial release
// ============================================================================
module spi_master_arb
  import spi_arb_pkg::*;
#(
  parameter int N = 4
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic [N-1:0]      req,
  input  logic [3*N-1:0]    req_len,
  input  logic [64*N-1:0]   req_data,
  output logic [N-1:0]      gnt,
  output logic [N-1:0]      done,
  output logic [63:0]       rsp_data,
  output logic              busy,
  output logic [7:0]        io_dout,
  output logic              io_empty,
  input  logic              io_read,
  input  logic [2:0]        io_spi_state,
  input  logic              io_rx_access,
  input  logic [63:0]       io_rx_data
);

  localparam int IDXW = (N > 1) ? $clog2(N) : 1;

  spi_arb_state_e  state_q, state_d;
  logic [IDXW-1:0] owner_q, owner_d;
  logic [IDXW-1:0] last_owner_q, last_owner_d;
  logic [63:0]     data_q, data_d;
  logic [2:0]      len_q, len_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [N-1:0]    gnt_q, gnt_d;
  logic [N-1:0]    done_q, done_d;
  logic [63:0]     rsp_data_q, rsp_data_d;
  logic [7:0]      io_dout_q, io_dout_d;

  logic [N-1:0]    w_sel;
  logic [IDXW-1:0] w_idx;
  logic            w_any;
  logic            w_last;
  logic [63:0]     w_data_arr [N];
  logic [2:0]      w_len_arr  [N];
  logic [7:0]      w_byte_arr [8];

  for (genvar gi = 0; gi < N; gi++) begin : g_unpack
    assign w_data_arr[gi] = req_data[64*gi +: 64];
    assign w_len_arr[gi]  = req_len[3*gi +: 3];
  end

  for (genvar gb = 0; gb < 8; gb++) begin : g_bytes
    assign w_byte_arr[gb] = data_q[8*gb +: 8];
  end

  spi_arb_rr #(
    .N    (N),
    .IDXW (IDXW)
  ) u_rr (
    .req        (req),
    .last_owner (last_owner_q),
    .sel        (w_sel),
    .idx        (w_idx),
    .any        (w_any)
  );

  // All bytes of the latched transaction have been handed out
  assign w_last = (cnt_q == ({1'b0, len_q} + 4'd1));

  // The grant cycle still reports empty so the first byte is offered one
  // cycle after gnt; any pop attempted in that cycle is ignored.
  assign io_empty = (state_q != SPI_ARB_SEND) || (gnt_q != '0) || w_last;
  assign busy     = (state_q != SPI_ARB_IDLE);
  assign gnt      = gnt_q;
  assign done     = done_q;
  assign rsp_data = rsp_data_q;
  assign io_dout  = io_dout_q;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    data_d       = data_q;
    len_d        = len_q;
    cnt_d        = cnt_q;
    gnt_d        = '0;
    done_d       = '0;
    rsp_data_d   = rsp_data_q;
    io_dout_d    = io_dout_q;

    case (state_q)
      SPI_ARB_IDLE: begin
        if (w_any) begin
          owner_d = w_idx;
          data_d  = w_data_arr[w_idx];
          len_d   = w_len_arr[w_idx];
          gnt_d   = w_sel;
          cnt_d   = '0;
          state_d = SPI_ARB_SEND;
        end
      end
      SPI_ARB_SEND: begin
        if (w_last) begin
          state_d = SPI_ARB_WAIT;
        end else if (io_read && !io_empty) begin
          io_dout_d = w_byte_arr[cnt_q[2:0]];
          cnt_d     = cnt_q + 4'd1;
        end
      end
      SPI_ARB_WAIT: begin
        if (io_rx_access) begin
          rsp_data_d   = io_rx_data;
          done_d       = {{(N-1){1'b0}}, 1'b1} << owner_q;
          last_owner_d = owner_q;
          state_d      = SPI_ARB_DRAIN;
        end
      end
      SPI_ARB_DRAIN: begin
        // Hold off the next grant until the engine leaves its margin state
        if (io_spi_state == SPI_IO_IDLE) begin
          state_d = SPI_ARB_IDLE;
        end
      end
      default: begin
        state_d = SPI_ARB_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q      <= SPI_ARB_IDLE;
      owner_q      <= '0;
      last_owner_q <= IDXW'(N-1);
      data_q       <= '0;
      len_q        <= '0;
      cnt_q        <= '0;
      gnt_q        <= '0;
      done_q       <= '0;
      rsp_data_q   <= '0;
      io_dout_q    <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      data_q       <= data_d;
      len_q        <= len_d;
      cnt_q        <= cnt_d;
      gnt_q        <= gnt_d;
      done_q       <= done_d;
      rsp_data_q   <= rsp_data_d;
      io_dout_q    <= io_dout_d;
    end
  end

endmodule : spi_master_arb
`default_nettype wire

// File: tb/tb_spi_master_arb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spi_master_arb
//  Purpose  : Self-checking bench for spi_master_arb. Expected bytes, owners
//             and receive words are queued as stimulus is applied and checked
//             as the design produces bytes and done pulses.
//  Revision : 1.0  initial release
// ============================================================================
module tb_spi_master_arb;

  localparam int N = 4;

  logic            clk = 1'b0;
  logic            nreset;
  logic [N-1:0]    req;
  logic [3*N-1:0]  req_len;
  logic [64*N-1:0] req_data;
  logic [N-1:0]    gnt;
  logic [N-1:0]    done;
  logic [63:0]     rsp_data;
  logic            busy;
  logic [7:0]      io_dout;
  logic            io_empty;
  logic            io_read;
  logic [2:0]      io_spi_state;
  logic            io_rx_access;
  logic [63:0]     io_rx_data;

  spi_master_arb #(.N(N)) dut (
    .clk          (clk),
    .nreset       (nreset),
    .req          (req),
    .req_len      (req_len),
    .req_data     (req_data),
    .gnt          (gnt),
    .done         (done),
    .rsp_data     (rsp_data),
    .busy         (busy),
    .io_dout      (io_dout),
    .io_empty     (io_empty),
    .io_read      (io_read),
    .io_spi_state (io_spi_state),
    .io_rx_access (io_rx_access),
    .io_rx_data   (io_rx_data)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0]  exp_byte_q [$];
  int          exp_own_q  [$];
  logic [63:0] exp_rsp_q  [$];
  logic [63:0] m_data [N];
  int          m_len  [N];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h required %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] oh(input int i);
    logic [63:0] one;
    one = 64'd1;
    return one << i;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int idx, input int len, input logic [63:0] data);
    req_len[3*idx +: 3]   = 3'(len);
    req_data[64*idx +: 64] = data;
    m_data[idx]           = data;
    m_len[idx]            = len;
    req[idx]              = 1'b1;
  endtask

  // Wait up to maxcyc cycles for a grant; queue the expected bytes and owner.
  task automatic wait_gnt(input int idx, input int maxcyc);
    int t;
    t = 0;
    do begin
      step();
      t++;
    end while (gnt == '0 && t < maxcyc);
    chk("gnt", gnt, oh(idx));
    chk("gnt_done_excl", done, 64'd0);
    for (int b = 0; b <= m_len[idx]; b++) exp_byte_q.push_back(m_data[idx][8*b +: 8]);
    exp_own_q.push_back(idx);
  endtask

  task automatic pop_n(input int n);
    int t;
    int popped;
    t = 0;
    popped = 0;
    while (popped < n && t < 200) begin
      if (!io_empty) begin
        io_read = 1'b1;
        step();
        io_read = 1'b0;
        chk("byte", io_dout, exp_byte_q.pop_front());
        popped++;
      end else begin
        step();
      end
      t++;
    end
    if (popped < n) chk("pop_timeout", 64'(popped), 64'(n));
  endtask

  task automatic pop_all();
    pop_n(exp_byte_q.size());
    exp_byte_q.delete();
    chk("empty_after_last", io_empty, 1);
  endtask

  task automatic finish_xfer(input logic [63:0] rx, input int drain);
    io_rx_data   = rx;
    io_rx_access = 1'b1;
    io_spi_state = 3'b100;
    exp_rsp_q.push_back(rx);
    step();
    io_rx_access = 1'b0;
    chk("done", done, oh(exp_own_q.pop_front()));
    chk("rsp", rsp_data, exp_rsp_q.pop_front());
    chk("gnt_done_excl", gnt, 64'd0);
    for (int i = 0; i < drain; i++) begin
      step();
      chk("drain_gnt", gnt, 64'd0);
      chk("drain_busy", busy, 1);
    end
    io_spi_state = 3'b000;
  endtask

  task automatic apply_reset();
    nreset = 1'b0;
    req = '0;
    io_read = 1'b0;
    io_rx_access = 1'b0;
    io_spi_state = 3'b000;
    repeat (3) step();
    chk("rst_gnt", gnt, 0);
    chk("rst_done", done, 0);
    chk("rst_rsp", rsp_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_dout", io_dout, 0);
    chk("rst_empty", io_empty, 1);
    nreset = 1'b1;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    req_len    = '0;
    req_data   = '0;
    io_rx_data = '0;
    apply_reset();

    // Single transfer with exact latencies
    issue(0, 1, 64'h0000_0000_0000_A55A);
    wait_gnt(0, 1);
    chk("gnt_cycle_empty", io_empty, 1);
    chk("gnt_cycle_busy", busy, 1);
    req = '0;
    step();
    chk("gnt_pulse", gnt, 0);
    chk("empty_fall", io_empty, 0);
    pop_all();
    step();
    finish_xfer(64'h1234, 0);
    step();
    chk("idle_busy", busy, 0);

    // Contention: grants 0,1,2,3,0 from reset
    apply_reset();
    for (int i = 0; i < N; i++) issue(i, 0, 64'hC0 + 64'(i));
    for (int k = 0; k < 5; k++) begin
      wait_gnt(k % N, 10);
      if (k == 4) req = '0;
      pop_all();
      step();
      finish_xfer(64'hD00 + 64'(k), 0);
    end
    step();

    // Request dropped right after its grant; full 8-byte transfer
    issue(2, 7, 64'hF0E1_D2C3_B4A5_9687);
    wait_gnt(2, 10);
    step();
    req = '0;
    pop_all();
    step();
    finish_xfer(64'hBEEF_0000_CAFE_0002, 0);
    step();

    // Spurious rx_access in IDLE and SEND, spurious pop while empty
    io_rx_data   = 64'hDEAD;
    io_rx_access = 1'b1;
    step();
    io_rx_access = 1'b0;
    chk("idle_spurious_done", done, 0);
    chk("idle_spurious_busy", busy, 0);
    issue(3, 2, 64'h0000_0000_0033_2211);
    wait_gnt(3, 10);
    req = '0;
    step();
    io_rx_access = 1'b1;
    step();
    io_rx_access = 1'b0;
    chk("send_spurious_done", done, 0);
    chk("send_spurious_busy", busy, 1);
    chk("send_spurious_empty", io_empty, 0);
    pop_all();
    io_read = 1'b1;
    step();
    io_read = 1'b0;
    chk("empty_pop_dout", io_dout, 8'h33);
    chk("empty_pop_empty", io_empty, 1);
    finish_xfer(64'h5555_AAAA_0000_0003, 0);
    step();

    // Drain hold: engine margin state delays the next grant
    issue(0, 0, 64'h77);
    issue(1, 1, 64'h9988);
    wait_gnt(0, 10);
    req[0] = 1'b0;
    pop_all();
    step();
    finish_xfer(64'h4444, 20);
    step();
    chk("release_idle_gnt", gnt, 0);
    chk("release_idle_busy", busy, 0);
    wait_gnt(1, 1);
    req = '0;
    pop_all();
    step();
    finish_xfer(64'h6666, 0);
    step();

    // Reset in the middle of SEND
    issue(2, 7, 64'h0807_0605_0403_0201);
    wait_gnt(2, 10);
    req = '0;
    pop_n(3);
    #2;
    nreset = 1'b0;
    #1;
    chk("abort_empty", io_empty, 1);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    exp_byte_q.delete();
    exp_own_q.delete();
    step();
    nreset = 1'b1;
    step();
    chk("post_abort_done", done, 0);
    issue(0, 0, 64'hA0);
    issue(1, 0, 64'hA1);
    issue(2, 0, 64'hA2);
    wait_gnt(0, 1);
    req = '0;
    pop_all();
    step();
    finish_xfer(64'h7777, 0);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_spi_master_arb
`default_nettype wire
